// File: rtl/counter_modn.sv
// Modulo-N up/down counter with synchronous load, combinational terminal count (tc)
// for same-cycle cascading, and a registered wrap pulse (co).
// Optional BCD outputs are enabled by defining COUNTER_MODN_BCD_EN.
module counter_modn #(
  parameter int unsigned MODULUS = 60,
  parameter int unsigned WIDTH   = 6
) (
  input  logic             clk,
  input  logic             ncr,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             co
`ifdef COUNTER_MODN_BCD_EN
  ,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
`endif
);

  localparam longint unsigned Span   = 64'd1 << WIDTH;
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  if ((MODULUS < 2) || (MODULUS > 256) || (Span < 64'(MODULUS))) begin : g_param_err
    $error("counter_modn: MODULUS must be 2..256 and fit in WIDTH bits");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             co_q, co_d;
  logic [WIDTH-1:0] load_val;

  // Out-of-range load values saturate at the top of the count range.
  assign load_val = (din > MaxVal) ? MaxVal : din;

`ifdef COUNTER_MODN_BCD_EN
  if (MODULUS > 100) begin : g_bcd_param_err
    $error("counter_modn: BCD outputs require MODULUS <= 100");
  end

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] val);
    int unsigned v;
    v = 32'(val);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
`endif

  // Next-state: load beats count; wraps use explicit compares, never natural overflow.
  always_comb begin
    out_d = out_q;
    co_d  = 1'b0;
`ifdef COUNTER_MODN_BCD_EN
    tens_d = tens_q;
    ones_d = ones_q;
`endif
    if (ld) begin
      out_d = load_val;
`ifdef COUNTER_MODN_BCD_EN
      {tens_d, ones_d} = to_bcd(load_val);
`endif
    end else if (en) begin
      if (out_q > MaxVal) begin
        // Only reachable through corruption; recover to zero.
        out_d = '0;
`ifdef COUNTER_MODN_BCD_EN
        tens_d = 4'd0;
        ones_d = 4'd0;
`endif
      end else if (up) begin
        if (out_q == MaxVal) begin
          out_d = '0;
          co_d  = 1'b1;
`ifdef COUNTER_MODN_BCD_EN
          tens_d = 4'd0;
          ones_d = 4'd0;
`endif
        end else begin
          out_d = out_q + One;
`ifdef COUNTER_MODN_BCD_EN
          if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
          end else begin
            ones_d = ones_q + 4'd1;
          end
`endif
        end
      end else begin
        if (out_q == '0) begin
          out_d = MaxVal;
          co_d  = 1'b1;
`ifdef COUNTER_MODN_BCD_EN
          {tens_d, ones_d} = to_bcd(MaxVal);
`endif
        end else begin
          out_d = out_q - One;
`ifdef COUNTER_MODN_BCD_EN
          if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else begin
            ones_d = ones_q - 4'd1;
          end
`endif
        end
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge ncr) begin
    if (!ncr) begin
      out_q <= '0;
      co_q  <= 1'b0;
`ifdef COUNTER_MODN_BCD_EN
      tens_q <= 4'd0;
      ones_q <= 4'd0;
`endif
    end else begin
      out_q <= out_d;
      co_q  <= co_d;
`ifdef COUNTER_MODN_BCD_EN
      tens_q <= tens_d;
      ones_q <= ones_d;
`endif
    end
  end

  assign out = out_q;
  assign co  = co_q;
  // Zero-latency terminal count so the next stage steps on the same edge.
  assign tc  = en & (up ? (out_q == MaxVal) : (out_q == '0));

`ifdef COUNTER_MODN_BCD_EN
  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;
`endif

endmodule
